// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 3-register window (TXDATA, STATUS, BAUD_DIV)
// feeding a small TX FIFO that drains through an 8N1 serializer.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_sig,
  input  logic [31:0] wr_data,
  input  logic [31:0] addr,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          sel;
  logic [1:0]    off;
  logic          wr_txdata, wr_status, wr_baud;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    count4;
  logic          full, empty, push, pop, ovf, busy;
  logic [15:0]   baud_div, div_active, baud_cnt;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift;
  logic          bit_end, tx_d;
  logic          unused;

  assign unused = ^{wr_data[31:16], addr[1:0]};

  // Address decode
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:2];
  assign wr_txdata = sel && wr_sig && (off == 2'd0);
  assign wr_status = sel && wr_sig && (off == 2'd1);
  assign wr_baud   = sel && wr_sig && (off == 2'd2);

  // FIFO: a push into a full FIFO survives only if the serializer pops that edge
  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_txdata && (!full || pop);
  assign count4 = 4'(count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data[7:0];
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (wr_txdata && full && !pop)    ovf <= 1'b1;
      else if (wr_status && wr_data[3]) ovf <= 1'b0;
      if (wr_baud) baud_div <= (wr_data[15:0] == '0) ? 16'd1 : wr_data[15:0];
    end
  end

  // Serializer FSM
  assign bit_end = (baud_cnt == div_active - 16'd1);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (!empty) begin
               pop     = 1'b1;
               state_d = START;
             end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_d = STOP;
      STOP:  if (bit_end) begin
               if (!empty) begin
                 pop     = 1'b1;
                 state_d = START;
               end else begin
                 state_d = IDLE;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered: compute the level for the state being entered
  always_comb begin
    bit_idx_d = bit_idx;
    if (state_q == DATA && bit_end) bit_idx_d = bit_idx + 3'd1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[bit_idx_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift      <= '0;
      div_active <= DEFAULT_DIV;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
    end else begin
      tx <= tx_d;
      if (pop) begin
        shift      <= fifo_mem[rd_ptr];
        div_active <= baud_div;
        baud_cnt   <= '0;
        bit_idx    <= '0;
      end else if (state_q != IDLE) begin
        bit_idx  <= bit_idx_d;
        baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
      end
    end
  end

  // Read mux: zero when not selected so it can be ORed with ram data
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (off)
        2'd1:    rd_data[7:0]  = {count4, ovf, empty, full, busy};
        2'd2:    rd_data[15:0] = baud_div;
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register table plus frame sequences.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset_n;
  logic        wr_sig;
  logic [31:0] wr_data;
  logic [31:0] addr;
  logic [31:0] rd_data;
  logic        tx;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(
    .BASE_ADDR  (32'h0000_1000),
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(16'd16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_sig (wr_sig),
    .wr_data(wr_data),
    .addr   (addr),
    .rd_data(rd_data),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr    = a;
    wr_data = d;
    wr_sig  = 1'b1;
    @(posedge clk);
    #1;
    wr_sig  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  // Entered start_off cycles after the start edge; ends 1ns after edge 10*div.
  task automatic frame_check(input logic [7:0] b, input int div, input int start_off);
    logic [9:0]  got, exp, mask;
    logic [31:0] st;
    int cur;
    exp  = {1'b1, b, 1'b0};
    got  = '0;
    mask = '0;
    cur  = start_off;
    for (int k = 0; k < 10; k++) begin
      int t;
      t = k * div + div / 2;
      if (t >= cur) begin
        if (t > cur) begin
          repeat (t - cur) @(posedge clk);
          #1;
        end
        cur     = t;
        got[k]  = tx;
        mask[k] = 1'b1;
      end
    end
    check($sformatf("frame_bits_%02h", b), 32'(got & mask), 32'(exp & mask));
    if (10 * div - 1 > cur) begin
      repeat (10 * div - 1 - cur) @(posedge clk);
      #1;
    end
    rd(32'h1004, st);
    check($sformatf("frame_tail_%02h", b), {30'd0, st[0], tx}, 32'h3);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v;
  logic [7:0]  burst [6];
  logic        stayed;

  initial begin
    reset_n = 1'b0;
    wr_sig  = 1'b0;
    wr_data = '0;
    addr    = '0;

    vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0, 32'h0000_0004};
    vecs[1]  = '{1'b0, 32'h0000_1008, 32'h0, 32'h0000_0010};
    vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_100C, 32'h0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0000_1014, 32'h0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_1006, 32'h0, 32'h0000_0004};
    vecs[7]  = '{1'b1, 32'h0000_1008, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_1008, 32'h0, 32'h0000_0001};
    vecs[9]  = '{1'b1, 32'h0000_100B, 32'hABCD_0025, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_1009, 32'h0, 32'h0000_0025};
    vecs[11] = '{1'b1, 32'h0000_100C, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_2000, 32'h0000_0077, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_1004, 32'h0, 32'h0000_0004};
    vecs[15] = '{1'b1, 32'h0000_1008, 32'h0000_0010, 32'h0};
    vecs[16] = '{1'b0, 32'h0000_1008, 32'h0, 32'h0000_0010};

    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'h1);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
      else begin
        rd(vecs[i].a, v);
        check($sformatf("vec%0d", i), v, vecs[i].exp);
      end
    end
    check("idle_tx", {31'd0, tx}, 32'h1);

    // Single frame, div=16
    bus_write(32'h1000, 32'h55);
    check("t2_pre_fall", {31'd0, tx}, 32'h1);
    @(posedge clk);
    #1;
    check("t2_fall", {31'd0, tx}, 32'h0);
    frame_check(8'h55, 16, 0);
    check("t2_end_tx", {31'd0, tx}, 32'h1);
    rd(32'h1004, v);
    check("t2_status", v, 32'h4);

    // Back-to-back frames, div=2
    bus_write(32'h1008, 32'h2);
    bus_write(32'h1000, 32'hA3);
    bus_write(32'h1000, 32'h0F);
    check("t3_fall", {31'd0, tx}, 32'h0);
    frame_check(8'hA3, 2, 0);
    check("t3_b2b", {31'd0, tx}, 32'h0);
    frame_check(8'h0F, 2, 0);
    rd(32'h1004, v);
    check("t3_status", v, 32'h4);

    // Overflow burst, div=4
    burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hC3;
    burst[3] = 8'h3C; burst[4] = 8'h7E; burst[5] = 8'h99;
    bus_write(32'h1008, 32'h4);
    for (int i = 0; i < 6; i++) begin
      bus_write(32'h1000, {24'd0, burst[i]});
      if (i == 1) check("t4_fall", {31'd0, tx}, 32'h0);
    end
    rd(32'h1004, v);
    check("t4_full_ovf", v, 32'h4B);
    frame_check(burst[0], 4, 4);
    check("t4_b2b1", {31'd0, tx}, 32'h0);
    rd(32'h1004, v);
    check("t4_status2", v, 32'h39);
    bus_write(32'h1004, 32'h8);
    rd(32'h1004, v);
    check("t4_ovf_clr", v, 32'h31);
    frame_check(burst[1], 4, 1);
    for (int j = 2; j < 5; j++) begin
      check($sformatf("t4_b2b%0d", j), {31'd0, tx}, 32'h0);
      frame_check(burst[j], 4, 0);
    end
    check("t4_end_tx", {31'd0, tx}, 32'h1);
    rd(32'h1004, v);
    check("t4_status_end", v, 32'h4);

    // Divider 0 -> 1, mid-frame divider change
    bus_write(32'h1008, 32'h0);
    rd(32'h1008, v);
    check("t5_div0", v, 32'h1);
    bus_write(32'h1000, 32'h5A);
    bus_write(32'h1000, 32'hC6);
    check("t5_fall", {31'd0, tx}, 32'h0);
    bus_write(32'h1008, 32'h8);
    rd(32'h1008, v);
    check("t5_div8", v, 32'h8);
    frame_check(8'h5A, 1, 1);
    check("t5_b2b", {31'd0, tx}, 32'h0);
    frame_check(8'hC6, 8, 0);
    rd(32'h1004, v);
    check("t5_status", v, 32'h4);

    // Asynchronous reset mid-DATA with bytes queued
    bus_write(32'h1000, 32'hF0);
    bus_write(32'h1000, 32'h0F);
    bus_write(32'h1000, 32'hAA);
    repeat (12) @(posedge clk);
    #1;
    check("t6_pre_tx", {31'd0, tx}, 32'h0);
    rd(32'h1004, v);
    check("t6_pre_status", v, 32'h21);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_async_tx", {31'd0, tx}, 32'h1);
    rd(32'h1004, v);
    check("t6_rst_status", v, 32'h4);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(32'h1004, v);
    check("t6_post_status", v, 32'h4);
    rd(32'h1008, v);
    check("t6_post_div", v, 32'h10);
    stayed = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) stayed = 1'b0;
    end
    check("t6_no_frames", {31'd0, stayed}, 32'h1);
    rd(32'h0000_0004, v);
    check("t6_unsel", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
